// File: rtl/vga_timing_if.sv
// Output bundle of the VGA timing generator: pixel/line counters plus the
// sync, blanking and frame-start strobes, all describing the same pixel.
interface vga_timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic        frame_start;

  // Timing generator side: drives every signal of the bundle.
  modport master (
    output hcount,
    output vcount,
    output hsync,
    output hblnk,
    output vsync,
    output vblnk,
    output frame_start
  );

  // Downstream draw/background stages: consume the bundle unchanged.
  modport slave (
    input hcount,
    input vcount,
    input hsync,
    input hblnk,
    input vsync,
    input vblnk,
    input frame_start
  );
endinterface : vga_timing_if

// File: rtl/vga_timing.sv
// Free-running VGA timing generator (800x600 @ 60 Hz by default, 40 MHz pclk).
// The next-state counts are computed combinationally, and every strobe is
// decoded from those next-state counts. Counts and strobes are then registered
// together, so each output cycle describes one single pixel with zero skew.
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic         pclk,
  input  logic         rst_n,
  vga_timing_if.master o_vga
);

  // Line/frame geometry. Totals must fit the 11-bit counters (<= 2048).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All compare points are constants derived from the geometry.
  localparam logic [10:0] LP_H_LAST        = 11'(H_TOTAL - 1);
  localparam logic [10:0] LP_V_LAST        = 11'(V_TOTAL - 1);
  localparam logic [10:0] LP_HBLNK_START   = 11'(H_ACTIVE);
  localparam logic [10:0] LP_HSYNC_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] LP_HSYNC_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] LP_VBLNK_START   = 11'(V_ACTIVE);
  localparam logic [10:0] LP_VSYNC_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] LP_VSYNC_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Registered state: counts plus strobes for the pixel currently presented.
  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_hblnk;
  logic        r_vsync;
  logic        r_vblnk;
  logic        r_frame_start;

  // Next-state counts and strobes decoded from them.
  logic        w_h_last;
  logic        w_v_last;
  logic [10:0] w_hcount_nxt;
  logic [10:0] w_vcount_nxt;
  logic        w_hsync_nxt;
  logic        w_hblnk_nxt;
  logic        w_vsync_nxt;
  logic        w_vblnk_nxt;
  logic        w_frame_start_nxt;

  // Wrap detection on the current pixel position.
  assign w_h_last = (r_hcount == LP_H_LAST);
  assign w_v_last = (r_vcount == LP_V_LAST);

  // Next-state counters: hcount always advances; vcount advances only on the
  // line wrap and itself wraps when the last line ends.
  always_comb begin
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_h_last) begin
      w_hcount_nxt = 11'd0;
      if (w_v_last) begin
        w_vcount_nxt = 11'd0;
      end else begin
        w_vcount_nxt = r_vcount + 11'd1;
      end
    end else begin
      w_hcount_nxt = r_hcount + 11'd1;
      w_vcount_nxt = r_vcount;
    end
  end

  // Strobe decode from the next-state counts so the registered strobes line
  // up exactly with the registered counts. The upper limits of both blanking
  // windows are the last count, which the counters never exceed.
  always_comb begin
    w_hblnk_nxt       = (w_hcount_nxt >= LP_HBLNK_START);
    w_hsync_nxt       = (w_hcount_nxt >= LP_HSYNC_START) &&
                        (w_hcount_nxt <= LP_HSYNC_END);
    w_vblnk_nxt       = (w_vcount_nxt >= LP_VBLNK_START);
    w_vsync_nxt       = (w_vcount_nxt >= LP_VSYNC_START) &&
                        (w_vcount_nxt <= LP_VSYNC_END);
    w_frame_start_nxt = (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
  end

  // Output registers. Reset parks on pixel (0,0) with matching strobes, so
  // frame_start is high while reset is held.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b1;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= w_hsync_nxt;
      r_hblnk       <= w_hblnk_nxt;
      r_vsync       <= w_vsync_nxt;
      r_vblnk       <= w_vblnk_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign o_vga.hcount      = r_hcount;
  assign o_vga.vcount      = r_vcount;
  assign o_vga.hsync       = r_hsync;
  assign o_vga.hblnk       = r_hblnk;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.vblnk       = r_vblnk;
  assign o_vga.frame_start = r_frame_start;

endmodule : vga_timing

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing. Two instances share clock and reset: one
// with the real 800x600 geometry (line-level behaviour) and one with a tiny
// geometry so whole frames fit in a short run. The reference model maps the
// number of clock edges since reset release to a pixel position with plain
// division/modulo and derives every strobe from range membership.
module tb_vga_timing;

  // Small geometry: H 16/2/3/2 (23 pixels), V 6/1/2/3 (12 lines).
  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } px_t;

  typedef struct packed {
    px_t  exp_s;
    px_t  exp_d;
    logic win;
  } sb_item_t;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;

  vga_timing_if bus_s ();
  vga_timing_if bus_d ();

  vga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .pclk (pclk),
    .rst_n(rst_n),
    .o_vga(bus_s.master)
  );

  vga_timing dut_d (
    .pclk (pclk),
    .rst_n(rst_n),
    .o_vga(bus_d.master)
  );

  always #5 pclk = ~pclk;

  sb_item_t sb_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;   // clock edges counted since reset release

  // Aggregates gathered by the monitor inside the measurement window.
  int win_active = 0, win_vsync = 0, win_vblnk = 0, win_fs = 0;
  int mon_cyc = 0, last_fs = -1;

  // Reference pixel for edge count tt under the given geometry.
  function automatic px_t ref_px(input int tt, input int ha, input int hf,
                                 input int hs, input int hb, input int va,
                                 input int vf, input int vs, input int vb);
    px_t p;
    int ht, vt, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    p.h  = 11'(h);
    p.v  = 11'(v);
    p.hb = (h >= ha);
    p.hs = (h >= ha + hf) && (h < ha + hf + hs);
    p.vb = (v >= va);
    p.vs = (v >= va + vf) && (v < va + vf + vs);
    p.fs = (h == 0) && (v == 0);
    return p;
  endfunction

  task automatic check_px(input string name, input px_t act, input px_t req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b required h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
               name, mon_cyc, act.h, act.v, act.hs, act.hb, act.vs, act.vb, act.fs,
               req.h, req.v, req.hs, req.hb, req.vs, req.vb, req.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops one expected item per cycle and compares mid-cycle.
  always @(negedge pclk) begin
    sb_item_t it;
    px_t act_s, act_d;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      act_s = {bus_s.hcount, bus_s.vcount, bus_s.hsync, bus_s.hblnk,
               bus_s.vsync, bus_s.vblnk, bus_s.frame_start};
      act_d = {bus_d.hcount, bus_d.vcount, bus_d.hsync, bus_d.hblnk,
               bus_d.vsync, bus_d.vblnk, bus_d.frame_start};
      check_px("small_px", act_s, it.exp_s);
      check_px("full_px", act_d, it.exp_d);
      if (it.win) begin
        if (!act_s.hb && !act_s.vb) win_active++;
        if (act_s.vs) win_vsync++;
        if (act_s.vb) win_vblnk++;
        if (act_s.fs) begin
          win_fs++;
          if (last_fs >= 0) check_int("frame_start_period", mon_cyc - last_fs, SFR);
          last_fs = mon_cyc;
        end
      end
      mon_cyc++;
    end
  end

  // Stimulus: one clock cycle, optionally asserting or releasing reset
  // between edges, then queue the expected outputs for that cycle.
  task automatic step(input bit do_assert, input bit do_release, input bit win);
    sb_item_t it;
    @(posedge pclk);
    if (rst_n) t++;
    #2;
    if (do_assert)  rst_n = 1'b0;
    if (do_release) rst_n = 1'b1;
    if (!rst_n) t = 0;
    it.exp_s = ref_px(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    it.exp_d = ref_px(t, 800, 40, 128, 88, 600, 1, 4, 23);
    it.win   = win;
    sb_q.push_back(it);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold, then release: counting starts with hcount = 1.
    repeat (10) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    // Long run: full geometry passes several line boundaries up to line 6,
    // small geometry wraps many frames.
    repeat (7000) step(1'b0, 1'b0, 1'b0);
    // Random asynchronous resets mid-frame with random hold lengths.
    repeat (6) begin
      int run_len, hold_len;
      run_len  = $urandom_range(400, 5);
      hold_len = $urandom_range(3, 0);
      repeat (run_len) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (hold_len) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    // Measurement window: exactly two small frames starting right after release.
    repeat (37) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (2 * SFR) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    @(negedge pclk);
    @(negedge pclk);

    check_int("queue_drained", sb_q.size(), 0);
    check_int("active_cycles_2frames", win_active, 2 * SHA * SVA);
    check_int("vsync_cycles_2frames", win_vsync, 2 * SVS * SHT);
    check_int("vblnk_cycles_2frames", win_vblnk, 2 * (SVT - SVA) * SHT);
    check_int("frame_start_pulses", win_fs, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_vga_timing
